// File: rtl/regfile_ctrl_if.sv
// Bundles the instruction handshake, register file access and retire-report
// signals of the register file sequencer.
// master: instruction source / register file side. slave: the sequencer.
interface regfile_ctrl_if #(
    parameter int DW   = 8,
    parameter int AW   = 3,
    parameter int CNTW = 16
);
    localparam int IW = 3 + 3 * AW + DW;

    logic            instr_valid;
    logic            instr_ready;
    logic [IW-1:0]   instr;
    logic [AW-1:0]   ra1;
    logic [AW-1:0]   ra2;
    logic [DW-1:0]   rd1;
    logic [DW-1:0]   rd2;
    logic [AW-1:0]   wa;
    logic [DW-1:0]   wd;
    logic            we;
    logic            res_valid;
    logic [DW-1:0]   res_data;
    logic            res_zero;
    logic            res_carry;
    logic [CNTW-1:0] retire_cnt;

    modport master (
        output instr_valid, instr, rd1, rd2,
        input  instr_ready, ra1, ra2, wa, wd, we,
               res_valid, res_data, res_zero, res_carry, retire_cnt
    );

    modport slave (
        input  instr_valid, instr, rd1, rd2,
        output instr_ready, ra1, ra2, wa, wd, we,
               res_valid, res_data, res_zero, res_carry, retire_cnt
    );
endinterface

// File: rtl/regfile_ctrl.sv
// Register file sequencer: accepts one micro-instruction, reads two operands,
// computes an 8-bit result and writes it back, one instruction per 3 cycles.
//
// state | meaning
// IDLE  | ready for an instruction; handshake latches op/dst/imm and read addrs
// EXEC  | read addresses driven; ALU result and carry registered at cycle end
// WRITE | write-back (skipped for NOP) and retire pulse; counter bumps at end
module regfile_ctrl #(
    parameter int DW   = 8,
    parameter int AW   = 3,
    parameter int CNTW = 16
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    regfile_ctrl_if.slave   bus
);
    localparam int IW = 3 + 3 * AW + DW;

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_LDI = 3'd6;
    localparam logic [2:0] OP_MOV = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            accept;

    logic [2:0]      op_q;
    logic [AW-1:0]   dst_q;
    logic [DW-1:0]   imm_q;
    logic [AW-1:0]   ra1_q;
    logic [AW-1:0]   ra2_q;
    logic [DW-1:0]   result_q;
    logic            zero_q;
    logic            carry_q;
    logic [AW-1:0]   wa_q;
    logic [DW-1:0]   wd_q;
    logic [CNTW-1:0] retire_cnt_q;

    logic [DW:0]     alu_ext;
    logic [DW-1:0]   alu_res;
    logic            alu_carry;

    logic            instr_ready_c;
    logic            we_c;
    logic            res_valid_c;

    assign accept = instr_ready_c && bus.instr_valid;

    // State register; reset wins over a same-cycle handshake.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state: each of EXEC and WRITE lasts exactly one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.instr_valid) state_nxt = EXEC;
            EXEC:    state_nxt = WRITE;
            WRITE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode; NOP retires without touching the register file.
    always_comb begin
        instr_ready_c = 1'b0;
        we_c          = 1'b0;
        res_valid_c   = 1'b0;
        case (state)
            IDLE:    instr_ready_c = 1'b1;
            WRITE: begin
                res_valid_c = 1'b1;
                we_c        = (op_q != OP_NOP);
            end
            default: ;
        endcase
    end

    // ALU on live register file data; the extra top bit carries out/borrow.
    always_comb begin
        alu_ext = '0;
        case (op_q)
            OP_ADD:  alu_ext = {1'b0, bus.rd1} + {1'b0, bus.rd2};
            OP_SUB:  alu_ext = {1'b0, bus.rd1} - {1'b0, bus.rd2};
            OP_AND:  alu_ext = {1'b0, bus.rd1 & bus.rd2};
            OP_OR:   alu_ext = {1'b0, bus.rd1 | bus.rd2};
            OP_XOR:  alu_ext = {1'b0, bus.rd1 ^ bus.rd2};
            OP_LDI:  alu_ext = {1'b0, imm_q};
            OP_MOV:  alu_ext = {1'b0, bus.rd1};
            default: alu_ext = '0;
        endcase
    end

    assign alu_res   = alu_ext[DW-1:0];
    assign alu_carry = alu_ext[DW];

    // Datapath registers; wa/wd only move for ops that actually write back.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            op_q         <= OP_NOP;
            dst_q        <= '0;
            imm_q        <= '0;
            ra1_q        <= '0;
            ra2_q        <= '0;
            result_q     <= '0;
            zero_q       <= 1'b0;
            carry_q      <= 1'b0;
            wa_q         <= '0;
            wd_q         <= '0;
            retire_cnt_q <= '0;
        end else begin
            if (accept) begin
                op_q  <= bus.instr[IW-1 -: 3];
                dst_q <= bus.instr[IW-4 -: AW];
                ra1_q <= bus.instr[IW-4-AW -: AW];
                ra2_q <= bus.instr[IW-4-2*AW -: AW];
                imm_q <= bus.instr[DW-1:0];
            end
            if (state == EXEC) begin
                result_q <= alu_res;
                zero_q   <= (alu_res == '0);
                carry_q  <= alu_carry;
                if (op_q != OP_NOP) begin
                    wa_q <= dst_q;
                    wd_q <= alu_res;
                end
            end
            if (state == WRITE) retire_cnt_q <= retire_cnt_q + CNTW'(1);
        end
    end

    assign bus.instr_ready = instr_ready_c;
    assign bus.ra1         = ra1_q;
    assign bus.ra2         = ra2_q;
    assign bus.wa          = wa_q;
    assign bus.wd          = wd_q;
    assign bus.we          = we_c;
    assign bus.res_valid   = res_valid_c;
    assign bus.res_data    = result_q;
    assign bus.res_zero    = zero_q;
    assign bus.res_carry   = carry_q;
    assign bus.retire_cnt  = retire_cnt_q;
endmodule

// File: tb/tb_regfile_ctrl.sv
// Directed bench for regfile_ctrl with a behavioural 8x8 register file.
// A second, narrow-counter instance exercises retire counter wrap quickly.
module tb_regfile_ctrl;
    logic sys_clk;
    logic sys_rst;

    regfile_ctrl_if #(.DW(8), .AW(3), .CNTW(16)) bus ();
    regfile_ctrl_if #(.DW(8), .AW(3), .CNTW(4))  bus2 ();

    regfile_ctrl #(.DW(8), .AW(3), .CNTW(16)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus.slave)
    );

    regfile_ctrl #(.DW(8), .AW(3), .CNTW(4)) dut_wrap (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus2.slave)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] rf [8];

    assign bus.rd1  = rf[bus.ra1];
    assign bus.rd2  = rf[bus.ra2];
    assign bus2.rd1 = 8'h00;
    assign bus2.rd2 = 8'h00;

    // Behavioural register file: written on the clock edge closing a we cycle.
    always @(posedge sys_clk) begin
        if (bus.we === 1'b1) rf[bus.wa] <= bus.wd;
    end

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic        timeout;
        logic        rdy1;
        logic        rv1;
        logic        we1;
        logic [2:0]  ra1;
        logic [2:0]  ra2;
        logic        rdy2;
        logic        rv2;
        logic        we2;
        logic [2:0]  wa;
        logic [7:0]  wd;
        logic [7:0]  rdata;
        logic        zero;
        logic        carry;
        logic        rdy3;
        logic        rv3;
        logic [15:0] cnt3;
    } obs_t;

    function automatic logic [19:0] enc(input logic [2:0] op, input logic [2:0] d,
                                        input logic [2:0] s1, input logic [2:0] s2,
                                        input logic [7:0] imm);
        return {op, d, s1, s2, imm};
    endfunction

    // Issues one instruction from a negedge and samples the three following negedges.
    task automatic run_instr(input logic [19:0] ins, output obs_t o);
        int n;
        o = '0;
        bus.instr       = ins;
        bus.instr_valid = 1'b1;
        n = 0;
        while (bus.instr_ready !== 1'b1 && n < 10) begin
            @(negedge sys_clk);
            n++;
        end
        if (n >= 10) begin
            o.timeout = 1'b1;
            total++;
            bad++;
            $display("FAIL accept_timeout ready never rose for instr=%h", ins);
        end
        @(negedge sys_clk);
        bus.instr_valid = 1'b0;
        o.rdy1 = bus.instr_ready; o.rv1 = bus.res_valid; o.we1 = bus.we;
        o.ra1  = bus.ra1;         o.ra2 = bus.ra2;
        @(negedge sys_clk);
        o.rdy2 = bus.instr_ready; o.rv2 = bus.res_valid; o.we2 = bus.we;
        o.wa   = bus.wa;          o.wd  = bus.wd;        o.rdata = bus.res_data;
        o.zero = bus.res_zero;    o.carry = bus.res_carry;
        @(negedge sys_clk);
        o.rdy3 = bus.instr_ready; o.rv3 = bus.res_valid; o.cnt3 = bus.retire_cnt;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        @(negedge sys_clk);
        @(negedge sys_clk);
        total++; if (bus.instr_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", bus.instr_ready); end
        total++; if (bus.we !== 1'b0 || bus.res_valid !== 1'b0) begin bad++; $display("FAIL rst_pulses we=%b rv=%b exp=0/0", bus.we, bus.res_valid); end
        total++; if ({bus.ra1, bus.ra2, bus.wa} !== 9'd0) begin bad++; $display("FAIL rst_addr ra1=%0d ra2=%0d wa=%0d exp=0", bus.ra1, bus.ra2, bus.wa); end
        total++; if ({bus.wd, bus.res_data} !== 16'h0000) begin bad++; $display("FAIL rst_data wd=%h res=%h exp=00", bus.wd, bus.res_data); end
        total++; if ({bus.res_zero, bus.res_carry} !== 2'b00) begin bad++; $display("FAIL rst_flags zero=%b carry=%b exp=0/0", bus.res_zero, bus.res_carry); end
        total++; if (bus.retire_cnt !== 16'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", bus.retire_cnt); end
        sys_rst = 1'b0;
        @(negedge sys_clk);
        total++; if (bus.instr_ready !== 1'b1 || bus.we !== 1'b0) begin bad++; $display("FAIL post_rst_idle ready=%b we=%b exp=1/0", bus.instr_ready, bus.we); end
    endtask

    task automatic test_add();
        obs_t o;
        run_instr(enc(3'd6, 3'd1, 3'd0, 3'd0, 8'h7f), o);
        total++; if (o.we2 !== 1'b1 || o.wa !== 3'd1 || o.wd !== 8'h7f) begin bad++; $display("FAIL ldi_r1 we=%b wa=%0d wd=%h exp=1/1/7f", o.we2, o.wa, o.wd); end
        run_instr(enc(3'd6, 3'd2, 3'd0, 3'd0, 8'h81), o);
        total++; if (o.wa !== 3'd2 || o.wd !== 8'h81 || o.carry !== 1'b0) begin bad++; $display("FAIL ldi_r2 wa=%0d wd=%h c=%b exp=2/81/0", o.wa, o.wd, o.carry); end
        run_instr(enc(3'd1, 3'd3, 3'd1, 3'd2, 8'h00), o);
        total++; if (o.rdy1 !== 1'b0 || o.rv1 !== 1'b0 || o.we1 !== 1'b0) begin bad++; $display("FAIL add_exec_cycle rdy=%b rv=%b we=%b exp=0/0/0", o.rdy1, o.rv1, o.we1); end
        total++; if (o.ra1 !== 3'd1 || o.ra2 !== 3'd2) begin bad++; $display("FAIL add_read_addr ra1=%0d ra2=%0d exp=1/2", o.ra1, o.ra2); end
        total++; if (o.rdy2 !== 1'b0 || o.rv2 !== 1'b1 || o.we2 !== 1'b1) begin bad++; $display("FAIL add_write_cycle rdy=%b rv=%b we=%b exp=0/1/1", o.rdy2, o.rv2, o.we2); end
        total++; if (o.wa !== 3'd3 || o.wd !== 8'h00 || o.rdata !== 8'h00) begin bad++; $display("FAIL add_result wa=%0d wd=%h res=%h exp=3/00/00", o.wa, o.wd, o.rdata); end
        total++; if (o.zero !== 1'b1 || o.carry !== 1'b1) begin bad++; $display("FAIL add_flags zero=%b carry=%b exp=1/1", o.zero, o.carry); end
        total++; if (o.rdy3 !== 1'b1 || o.rv3 !== 1'b0) begin bad++; $display("FAIL add_ready_back rdy=%b rv=%b exp=1/0", o.rdy3, o.rv3); end
        total++; if (o.cnt3 !== 16'd3) begin bad++; $display("FAIL add_cnt got=%0d exp=3", o.cnt3); end
    endtask

    task automatic test_sub();
        obs_t o;
        run_instr(enc(3'd2, 3'd4, 3'd2, 3'd1, 8'h00), o);
        total++; if (o.wa !== 3'd4 || o.wd !== 8'h02 || o.carry !== 1'b0 || o.zero !== 1'b0) begin bad++; $display("FAIL sub_no_borrow wa=%0d wd=%h c=%b z=%b exp=4/02/0/0", o.wa, o.wd, o.carry, o.zero); end
        run_instr(enc(3'd2, 3'd5, 3'd1, 3'd2, 8'h00), o);
        total++; if (o.wa !== 3'd5 || o.wd !== 8'hfe || o.carry !== 1'b1) begin bad++; $display("FAIL sub_borrow wa=%0d wd=%h c=%b exp=5/fe/1", o.wa, o.wd, o.carry); end
        total++; if (o.cnt3 !== 16'd5) begin bad++; $display("FAIL sub_cnt got=%0d exp=5", o.cnt3); end
    endtask

    task automatic test_logic();
        obs_t o;
        run_instr(enc(3'd3, 3'd6, 3'd1, 3'd2, 8'h00), o);
        total++; if (o.wd !== 8'h01 || o.carry !== 1'b0) begin bad++; $display("FAIL and wd=%h c=%b exp=01/0", o.wd, o.carry); end
        run_instr(enc(3'd4, 3'd7, 3'd1, 3'd2, 8'h00), o);
        total++; if (o.wa !== 3'd7 || o.wd !== 8'hff) begin bad++; $display("FAIL or wa=%0d wd=%h exp=7/ff", o.wa, o.wd); end
        run_instr(enc(3'd5, 3'd6, 3'd1, 3'd2, 8'h00), o);
        total++; if (o.wd !== 8'hfe) begin bad++; $display("FAIL xor wd=%h exp=fe", o.wd); end
        run_instr(enc(3'd7, 3'd0, 3'd2, 3'd5, 8'h00), o);
        total++; if (o.wa !== 3'd0 || o.wd !== 8'h81 || o.carry !== 1'b0) begin bad++; $display("FAIL mov wa=%0d wd=%h c=%b exp=0/81/0", o.wa, o.wd, o.carry); end
        run_instr(enc(3'd6, 3'd5, 3'd7, 3'd7, 8'h3c), o);
        total++; if (o.wa !== 3'd5 || o.wd !== 8'h3c || o.ra1 !== 3'd7) begin bad++; $display("FAIL ldi_imm wa=%0d wd=%h ra1=%0d exp=5/3c/7", o.wa, o.wd, o.ra1); end
        total++; if (o.cnt3 !== 16'd10) begin bad++; $display("FAIL logic_cnt got=%0d exp=10", o.cnt3); end
    endtask

    task automatic test_back_to_back();
        logic [19:0] prog [4];
        int k = 0;
        int we_cnt = 0;
        int rdy_low = 0;
        int first_we = -1;
        int last_we = -1;
        int bad_gap = 0;
        logic [7:0] last_wd = 8'h00;
        prog[0] = enc(3'd6, 3'd1, 3'd0, 3'd0, 8'h10);
        prog[1] = enc(3'd6, 3'd2, 3'd0, 3'd0, 8'h20);
        prog[2] = enc(3'd1, 3'd3, 3'd1, 3'd2, 8'h00);
        prog[3] = enc(3'd5, 3'd4, 3'd3, 3'd1, 8'h00);
        for (int c = 0; c < 12; c++) begin
            if (bus.instr_ready === 1'b1) begin
                if (k < 4) begin
                    bus.instr       = prog[k];
                    bus.instr_valid = 1'b1;
                    k++;
                end else begin
                    bus.instr_valid = 1'b0;
                end
            end else begin
                rdy_low++;
            end
            if (bus.we === 1'b1) begin
                if (first_we < 0) first_we = c;
                if (last_we >= 0 && c - last_we != 3) bad_gap++;
                last_we = c;
                we_cnt++;
                last_wd = bus.wd;
            end
            @(negedge sys_clk);
        end
        bus.instr_valid = 1'b0;
        total++; if (we_cnt != 4) begin bad++; $display("FAIL b2b_we_count got=%0d exp=4", we_cnt); end
        total++; if (rdy_low != 8) begin bad++; $display("FAIL b2b_ready_low got=%0d exp=8", rdy_low); end
        total++; if (first_we != 2 || bad_gap != 0) begin bad++; $display("FAIL b2b_spacing first=%0d badgaps=%0d exp=2/0", first_we, bad_gap); end
        total++; if (last_wd !== 8'h20) begin bad++; $display("FAIL b2b_last_wd got=%h exp=20", last_wd); end
        total++; if (bus.retire_cnt !== 16'd14) begin bad++; $display("FAIL b2b_cnt got=%0d exp=14", bus.retire_cnt); end
    endtask

    task automatic test_raw();
        obs_t o;
        run_instr(enc(3'd6, 3'd0, 3'd0, 3'd0, 8'h05), o);
        total++; if (o.wd !== 8'h05) begin bad++; $display("FAIL raw_ldi wd=%h exp=05", o.wd); end
        run_instr(enc(3'd1, 3'd0, 3'd0, 3'd0, 8'h00), o);
        total++; if (o.wd !== 8'h0a) begin bad++; $display("FAIL raw_add1 wd=%h exp=0a", o.wd); end
        run_instr(enc(3'd1, 3'd0, 3'd0, 3'd0, 8'h00), o);
        total++; if (o.wa !== 3'd0 || o.wd !== 8'h14) begin bad++; $display("FAIL raw_add2 wa=%0d wd=%h exp=0/14", o.wa, o.wd); end
    endtask

    task automatic test_nop_and_reset();
        obs_t o;
        logic seen;
        run_instr(enc(3'd0, 3'd6, 3'd1, 3'd2, 8'haa), o);
        total++; if (o.rv2 !== 1'b1 || o.we2 !== 1'b0) begin bad++; $display("FAIL nop_pulses rv=%b we=%b exp=1/0", o.rv2, o.we2); end
        total++; if (o.rdata !== 8'h00 || o.zero !== 1'b1 || o.carry !== 1'b0) begin bad++; $display("FAIL nop_result res=%h z=%b c=%b exp=00/1/0", o.rdata, o.zero, o.carry); end
        total++; if (o.wa !== 3'd0 || o.wd !== 8'h14) begin bad++; $display("FAIL nop_hold wa=%0d wd=%h exp=0/14", o.wa, o.wd); end
        total++; if (o.cnt3 !== 16'd18) begin bad++; $display("FAIL nop_cnt got=%0d exp=18", o.cnt3); end

        bus.instr       = enc(3'd1, 3'd3, 3'd1, 3'd2, 8'h00);
        bus.instr_valid = 1'b1;
        @(negedge sys_clk);
        bus.instr_valid = 1'b0;
        total++; if (bus.instr_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_in_exec ready=%b exp=0", bus.instr_ready); end
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        total++; if (bus.instr_ready !== 1'b1 || bus.retire_cnt !== 16'd0) begin bad++; $display("FAIL mid_rst_state ready=%b cnt=%0d exp=1/0", bus.instr_ready, bus.retire_cnt); end
        seen = (bus.we !== 1'b0) || (bus.res_valid !== 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge sys_clk);
            if (bus.we !== 1'b0 || bus.res_valid !== 1'b0) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL mid_rst_no_retire saw we/res_valid=1 exp=none"); end
        total++; if (bus.retire_cnt !== 16'd0 || rf[3] !== 8'h30) begin bad++; $display("FAIL mid_rst_after cnt=%0d r3=%h exp=0/30", bus.retire_cnt, rf[3]); end
    endtask

    task automatic test_wrap();
        int n;
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        bus2.instr       = '0;
        bus2.instr_valid = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            n = 0;
            while (bus2.res_valid !== 1'b1 && n < 8) begin
                @(negedge sys_clk);
                n++;
            end
            if (n >= 8) begin
                total++;
                bad++;
                $display("FAIL wrap_timeout no retire for nop %0d", k);
                break;
            end
            @(negedge sys_clk);
            if (k == 15) begin
                total++; if (bus2.retire_cnt !== 4'hf) begin bad++; $display("FAIL wrap_max got=%h exp=f", bus2.retire_cnt); end
            end
            if (k == 16) begin
                total++; if (bus2.retire_cnt !== 4'h0) begin bad++; $display("FAIL wrap_zero got=%h exp=0", bus2.retire_cnt); end
            end
        end
        bus2.instr_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) rf[i] = 8'h00;
        sys_rst          = 1'b1;
        bus.instr_valid  = 1'b0;
        bus.instr        = '0;
        bus2.instr_valid = 1'b0;
        bus2.instr       = '0;
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_back_to_back();
        test_raw();
        test_nop_and_reset();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/regfile_ctrl.md
Name: regfile_ctrl

Overview:
- Initiator-side sequencer for the 8x8 register file.
- Accepts one micro-instruction at a time over a valid/ready handshake.
- Drives the register file's two read addresses, samples rd1/rd2, computes an 8-bit result and issues the write-back (wa/wd/we).
- Sits between the instruction source (test/CPU front end) and the register file; reports each retired result and a retire count.

Parameters:
- DW, 8, data width; must match register file width.
- AW, 3, register address width (8 registers).
- CNTW, 16, width of retire counter.

Ports:
- sys_clk  input  1  system clock, all logic on rising edge.
- sys_rst  input  1  synchronous active-high reset.
- instr_valid  input  1  instruction present.
- instr_ready  output  1  controller can accept an instruction.
- instr  input  20  {op[19:17], dst[16:14], src1[13:11], src2[10:8], imm[7:0]}.
- ra1  output  AW  register file read address 1.
- ra2  output  AW  register file read address 2.
- rd1  input  DW  register file read data 1 (combinational from ra1).
- rd2  input  DW  register file read data 2 (combinational from ra2).
- wa  output  AW  write address.
- wd  output  DW  write data.
- we  output  1  write enable, one-cycle pulse.
- res_valid  output  1  one-cycle pulse, result retired.
- res_data  output  DW  retired result.
- res_zero  output  1  res_data == 0.
- res_carry  output  1  carry/borrow of retired op.
- retire_cnt  output  CNTW  count of retired instructions.

Behaviour:
- Opcodes: 000 NOP, 001 ADD (src1+src2), 010 SUB (src1-src2), 011 AND, 100 OR, 101 XOR, 110 LDI (imm), 111 MOV (src1).
- Arithmetic modulo 2^DW.
  - ADD carry = bit DW of the (DW+1)-bit sum.
  - SUB carry = borrow, i.e. 1 iff src1 < src2 unsigned.
  - Carry = 0 for all other ops.
- FSM states: IDLE, EXEC, WRITE.
  - IDLE: instr_ready=1. On instr_valid & instr_ready, latch instr and go to EXEC. Without valid, stay in IDLE.
  - EXEC: instr_ready=0. ra1=src1 and ra2=src2 (latched). Compute from rd1/rd2/imm; register result and carry at the end of the cycle. Go to WRITE.
  - WRITE: instr_ready=0. wa=dst, wd=result. we=1 unless op=NOP. res_valid=1, res_data=result (NOP result=0), res_zero, res_carry valid. retire_cnt increments at the end of the cycle. Go to IDLE.
- Latency: instruction accepted at edge T → we/res_valid high during cycle T+2 → register file updated at edge T+3 → instr_ready high again in cycle T+3.
  - Throughput is 1 instruction per 3 cycles.
- Hazards: the next instruction's EXEC always follows the prior write edge, so read-after-write returns new data with no forwarding. dst == src allowed.
- ra1/ra2 outside EXEC hold their last value (0 after reset). wa/wd hold when we=0.
- retire_cnt wraps from 2^CNTW-1 to 0. NOP counts as retired.
- Reset values:
  - state = IDLE, instr_ready = 1 in the cycle after reset.
  - ra1 = ra2 = wa = 0, wd = 0, we = 0.
  - res_valid = 0, res_data = 0, res_zero = 0, res_carry = 0, retire_cnt = 0.
- Reset mid-operation: the in-flight instruction is discarded. No we or res_valid is issued after the reset edge. The register file is not cleared by this block.
- instr_valid while busy is ignored; the source must hold it until accepted. instr is sampled only at the handshake edge.
- Reset dominates a handshake in the same cycle.

Test Plan:
- LDI r1 ← 0x7F, then LDI r2 ← 0x81, then ADD r3=r1+r2 → we at T+2 with wa=3, wd=0x00, res_zero=1, res_carry=1; retire_cnt=3.
- SUB r4 = r2 - r1 (0x81 - 0x7F) → wd=0x02, carry=0. Then SUB r5 = r1 - r2 → wd=0xFE, carry=1.
- Back-to-back valid held high for 4 instructions → instr_ready low 2 of every 3 cycles, exactly 4 we pulses, 3-cycle spacing.
- RAW chain with LDI r0 ← 5, ADD r0=r0+r0, ADD r0=r0+r0 → final wd=0x14, each read sees the prior write.
- NOP → res_valid=1, res_data=0, we=0, retire_cnt increments. Assert sys_rst during EXEC of an ADD → no we or res_valid follows, retire_cnt=0, instr_ready=1 the next cycle.
- Preload retire_cnt near wrap by running 65535 NOPs, then 1 more → retire_cnt=0x0000.
